// File: rtl/ram_handshake_mem.sv
// Byte-addressable big-endian RAM behind the MOV/MOC four-phase handshake,
// with WAIT_STATES programmable wait cycles. Optional macro: RAM_ALIGN_FAULT_EN.
module ram_handshake_mem #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Enable,
    input  logic        ReadWrite,
    input  logic        MOV,
    input  logic [1:0]  Size,
    input  logic        SignExt,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        Fault
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] WS = WAIT_STATES[3:0];

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

    state_t state, next_state;

    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              rw_q;
    logic              sext_q;
    logic [31:0]       wdata_q;
    logic              moc_q;

    logic [7:0]        mem [0:DEPTH-1];

    logic [ADDR_W-1:0] eff_addr, a1, a2, a3;
    logic [7:0]        b0, b1, b2, b3;
    logic [31:0]       rdata;
    logic              access_fault;

    // Address bits above ADDR_W deliberately wrap away
    logic unused_addr_bits;
    assign unused_addr_bits = ^Address[31:ADDR_W];

`ifdef RAM_ALIGN_FAULT_EN
    logic fault_q;
    logic misaligned;

    assign misaligned   = (size_q == 2'b01 && addr_q[0]) ||
                          (size_q[1] && addr_q[1:0] != 2'b00);
    assign access_fault = misaligned;
    assign eff_addr     = addr_q;
    assign Fault        = fault_q;
`else
    assign access_fault = 1'b0;
    assign Fault        = 1'b0;

    always_comb begin
        eff_addr = addr_q;
        case (size_q)
            2'b01:        eff_addr = {addr_q[ADDR_W-1:1], 1'b0};
            2'b10, 2'b11: eff_addr = {addr_q[ADDR_W-1:2], 2'b00};
            default:      eff_addr = addr_q;
        endcase
    end
`endif

    assign a1 = eff_addr + ADDR_W'(1);
    assign a2 = eff_addr + ADDR_W'(2);
    assign a3 = eff_addr + ADDR_W'(3);

    always_comb begin
        b0 = mem[eff_addr];
        b1 = mem[a1];
        b2 = mem[a2];
        b3 = mem[a3];
        rdata = {b0, b1, b2, b3};
        case (size_q)
            2'b00:   rdata = sext_q ? {{24{b0[7]}}, b0} : {24'h0, b0};
            2'b01:   rdata = sext_q ? {{16{b0[7]}}, b0, b1} : {16'h0, b0, b1};
            default: rdata = {b0, b1, b2, b3};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (Enable && MOV) begin
                    next_state = (WAIT_STATES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: next_state = DONE;
            DONE: begin
                if (!MOV) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Request capture, wait countdown and registered response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 4'd0;
            addr_q   <= '0;
            size_q   <= 2'b00;
            rw_q     <= 1'b0;
            sext_q   <= 1'b0;
            wdata_q  <= 32'h0;
            DataOut  <= 32'h0;
            moc_q    <= 1'b0;
`ifdef RAM_ALIGN_FAULT_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Enable && MOV) begin
                        addr_q   <= Address[ADDR_W-1:0];
                        size_q   <= Size;
                        rw_q     <= ReadWrite;
                        sext_q   <= SignExt;
                        wdata_q  <= DataIn;
                        wait_cnt <= WS;
                    end
                end
                WAIT: wait_cnt <= wait_cnt - 4'd1;
                ACCESS: begin
                    moc_q <= 1'b1;
`ifdef RAM_ALIGN_FAULT_EN
                    fault_q <= access_fault;
`endif
                    if (rw_q && !access_fault) begin
                        DataOut <= rdata;
                    end
                end
                DONE: begin
                    if (!MOV) begin
                        moc_q <= 1'b0;
`ifdef RAM_ALIGN_FAULT_EN
                        fault_q <= 1'b0;
`endif
                    end
                end
                default: moc_q <= 1'b0;
            endcase
        end
    end

    assign MOC = moc_q;

    // Storage is never reset; an async reset leaves ACCESS unreachable so no stray write
    always_ff @(posedge clk) begin
        if (state == ACCESS && !rw_q && !access_fault) begin
            case (size_q)
                2'b00: mem[eff_addr] <= wdata_q[7:0];
                2'b01: begin
                    mem[eff_addr] <= wdata_q[15:8];
                    mem[a1]       <= wdata_q[7:0];
                end
                default: begin
                    mem[eff_addr] <= wdata_q[31:24];
                    mem[a1]       <= wdata_q[23:16];
                    mem[a2]       <= wdata_q[15:8];
                    mem[a3]       <= wdata_q[7:0];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_handshake_mem.sv
// Scoreboard bench for ram_handshake_mem: a WAIT_STATES=2 instance and a
// WAIT_STATES=0 instance, directed vectors with hand-computed results.
module tb_ram_handshake_mem;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        readWrite;
    logic        movReq;
    logic [1:0]  size;
    logic        signExt;
    logic [31:0] address;
    logic [31:0] dataIn;
    logic        sel;

    logic        mov, mov0;
    logic [31:0] dataOut, dataOut0;
    logic        moc, moc0;
    logic        fault, fault0;

    logic        mocSel, faultSel, mocPrev;
    logic [31:0] dataSel;

    typedef struct {
        logic [31:0] data;
        logic        fault;
    } resp_t;

    resp_t       sbQueue[$];
    logic [31:0] lastRead [0:1];
    int          checks;
    int          errors;

    assign mov      = sel ? 1'b0 : movReq;
    assign mov0     = sel ? movReq : 1'b0;
    assign mocSel   = sel ? moc0 : moc;
    assign faultSel = sel ? fault0 : fault;
    assign dataSel  = sel ? dataOut0 : dataOut;

    ram_handshake_mem #(.ADDR_W(8), .WAIT_STATES(2)) dut (
        .clk(clk), .reset_n(reset_n), .Enable(enable), .ReadWrite(readWrite),
        .MOV(mov), .Size(size), .SignExt(signExt), .Address(address),
        .DataIn(dataIn), .DataOut(dataOut), .MOC(moc), .Fault(fault)
    );

    ram_handshake_mem #(.ADDR_W(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .Enable(enable), .ReadWrite(readWrite),
        .MOV(mov0), .Size(size), .SignExt(signExt), .Address(address),
        .DataIn(dataIn), .DataOut(dataOut0), .MOC(moc0), .Fault(fault0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every rising MOC consumes one scoreboard entry
    always @(negedge clk) begin
        resp_t exp;
        if (mocSel && !mocPrev) begin
            if (sbQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_moc: got MOC=1, expected no response");
            end else begin
                exp = sbQueue.pop_front();
                checkOutput("resp_data", dataSel, exp.data);
                checkOutput("resp_fault", {31'h0, faultSel}, {31'h0, exp.fault});
            end
        end
        mocPrev = mocSel;
    end

    // One full handshake; inputs are scrambled right after acceptance
    task automatic applyStimulus(input logic rw, input logic [1:0] sz, input logic sx,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expData, input logic expFault,
                                 input int holdCycles);
        resp_t r;
        int    cycles;
        int    highCnt;
        int    expLat;
        expLat  = sel ? 1 : 3;
        r.fault = expFault;
        r.data  = (rw && !expFault) ? expData : lastRead[sel];
        lastRead[sel] = r.data;
        sbQueue.push_back(r);

        @(negedge clk);
        enable = 1'b1; readWrite = rw; size = sz; signExt = sx;
        address = addr; dataIn = wdata; movReq = 1'b1;
        @(posedge clk);
        #1;
        address = $urandom; dataIn = $urandom; size = 2'($urandom);
        signExt = ~sx; readWrite = ~rw; enable = 1'b0;

        cycles = 0;
        while (!mocSel && cycles < 50) begin
            cycles++;
            @(posedge clk);
            #1;
        end
        checkOutput("moc_latency", cycles, expLat);

        highCnt = 0;
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            if (mocSel) highCnt++;
        end
        if (holdCycles > 0) checkOutput("moc_hold", highCnt, holdCycles);

        @(negedge clk);
        movReq = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("moc_drop", {31'h0, mocSel}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int highCnt;
        checks = 0; errors = 0;
        reset_n = 1'b0; enable = 1'b0; readWrite = 1'b0; movReq = 1'b0;
        size = 2'b00; signExt = 1'b0; address = 32'h0; dataIn = 32'h0;
        sel = 1'b0; mocPrev = 1'b0;
        lastRead[0] = 32'h0; lastRead[1] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_moc", {31'h0, moc}, 32'h0);
        checkOutput("reset_fault", {31'h0, fault}, 32'h0);
        checkOutput("reset_dataout", dataOut, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Preload 40..43 with E7 D1 20 00
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd40, 32'h0000_00E7, 32'h0, 1'b0, 0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd41, 32'h0000_00D1, 32'h0, 1'b0, 0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd42, 32'h0000_0020, 32'h0, 1'b0, 0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd43, 32'h0000_0000, 32'h0, 1'b0, 0);
        applyStimulus(1'b1, 2'b10, 1'b1, 32'd40, 32'h0, 32'hE7D1_2000, 1'b0, 0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0128, 32'h0, 32'hE7D1_2000, 1'b0, 0);

        // Byte write into the middle of a word leaves its neighbours alone
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd4, 32'h1122_3344, 32'h0, 1'b0, 0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd5, 32'h0000_00A5, 32'h0, 1'b0, 0);
        applyStimulus(1'b1, 2'b00, 1'b1, 32'd5, 32'h0, 32'hFFFF_FFA5, 1'b0, 0);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'd5, 32'h0, 32'h0000_00A5, 1'b0, 0);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'd4, 32'h0, 32'h0000_0011, 1'b0, 0);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'd6, 32'h0, 32'h0000_0033, 1'b0, 0);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'd7, 32'h0, 32'h0000_0044, 1'b0, 0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'd4, 32'h0, 32'h11A5_3344, 1'b0, 0);

        // Halfword write/read with sign extension
        applyStimulus(1'b0, 2'b01, 1'b0, 32'd2, 32'h1234_8001, 32'h0, 1'b0, 0);
        applyStimulus(1'b1, 2'b01, 1'b1, 32'd2, 32'h0, 32'hFFFF_8001, 1'b0, 0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'd2, 32'h0, 32'h0000_8001, 1'b0, 0);

        // Misaligned accesses near the top of memory
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd252, 32'hAABB_CCDD, 32'h0, 1'b0, 0);
`ifdef RAM_ALIGN_FAULT_EN
        applyStimulus(1'b1, 2'b10, 1'b0, 32'd254, 32'h0, 32'h0, 1'b1, 0);
        applyStimulus(1'b1, 2'b01, 1'b1, 32'd253, 32'h0, 32'h0, 1'b1, 0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd254, 32'h1111_1111, 32'h0, 1'b1, 0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'd252, 32'h0, 32'hAABB_CCDD, 1'b0, 0);
`else
        applyStimulus(1'b1, 2'b10, 1'b0, 32'd254, 32'h0, 32'hAABB_CCDD, 1'b0, 0);
        applyStimulus(1'b1, 2'b01, 1'b1, 32'd253, 32'h0, 32'hFFFF_AABB, 1'b0, 0);
`endif
        applyStimulus(1'b1, 2'b11, 1'b0, 32'd252, 32'h0, 32'hAABB_CCDD, 1'b0, 0);

        // MOV held through DONE, then a back-to-back request
        applyStimulus(1'b1, 2'b00, 1'b0, 32'd42, 32'h0, 32'h0000_0020, 1'b0, 10);
        applyStimulus(1'b1, 2'b00, 1'b1, 32'd41, 32'h0, 32'hFFFF_FFD1, 1'b0, 0);

        // Reset during WAIT discards the pending write
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd8, 32'h0BAD_F00D, 32'h0, 1'b0, 0);
        @(negedge clk);
        enable = 1'b1; readWrite = 1'b0; size = 2'b10; address = 32'd8;
        dataIn = 32'hDEAD_BEEF; movReq = 1'b1;
        @(posedge clk);
        #1;
        movReq = 1'b0; enable = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midop_reset_moc", {31'h0, moc}, 32'h0);
        checkOutput("midop_reset_dataout", dataOut, 32'h0);
        lastRead[0] = 32'h0;
        lastRead[1] = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        highCnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (moc) highCnt++;
        end
        checkOutput("midop_no_moc", highCnt, 0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'd8, 32'h0, 32'h0BAD_F00D, 1'b0, 0);

        // Enable low: MOV is ignored
        @(negedge clk);
        enable = 1'b0; readWrite = 1'b1; size = 2'b10; address = 32'd40; movReq = 1'b1;
        highCnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (moc) highCnt++;
        end
        checkOutput("disabled_moc", highCnt, 0);
        @(negedge clk);
        movReq = 1'b0;
        @(negedge clk);

        // Zero wait states on the second instance
        sel = 1'b1;
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'hCAFE_F00D, 32'h0, 1'b0, 0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'hCAFE_F00D, 1'b0, 0);
        applyStimulus(1'b1, 2'b00, 1'b1, 32'h13, 32'h0, 32'h0000_000D, 1'b0, 0);
        @(negedge clk);
        sel = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_empty", sbQueue.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
